mem_bus_arbiter: RTL and testbench

- Sits directly downstream of the I-cache and D-cache. Owns the single system-bus port and grants it to one cache at a time, using the busreq / busgrant / busidle handshake both caches implement.
- Muxes the granted master's request bundle onto the bus.
- Routes read/write responses back to the owner only.
- Broadcasts snoop-invalidate responses (resptag == INV_TAG) to both caches regardless of ownership.

---
 rtl/mem_bus_arbiter.sv | 172 +++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Owns the single system-bus port shared by the I-cache and the D-cache and
//   grants it to one cache at a time using the busreq / busgrant / busidle
//   handshake. The owner's request bundle is muxed onto the bus. Read and
//   write responses go back to the owner only. Snoop-invalidate responses
//   (resptag == INV_TAG) are broadcast to both caches.
//
// Ports
//   clk, reset                 clock, asynchronous active-low reset
//   {ic,dc}_busreq             cache asks for bus ownership
//   {ic,dc}_busidle            cache has no bus transaction in flight
//   {ic,dc}_busgrant           ownership grant, held while owned
//   {ic,dc}_reqcyc/req/reqtag  per-master request bundle
//   {ic,dc}_respack            per-master response acknowledge
//   {ic,dc}_reqack/respcyc     bus handshakes routed to owner (or broadcast)
//   {ic,dc}_resp/resptag       bus response fanout to both masters
//   bus_reqcyc/req/reqtag/respack   request side toward the system bus
//   bus_reqack/respcyc/resp/resptag response side from the system bus
module mem_bus_arbiter #(
    parameter int                       BUS_DATA_WIDTH = 64,
    parameter int                       BUS_TAG_WIDTH  = 13,
    parameter logic [BUS_TAG_WIDTH-1:0] INV_TAG        = 13'h800,
    parameter int                       START_TIMEOUT  = 16
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      ic_busreq,
    input  logic                      dc_busreq,
    input  logic                      ic_busidle,
    input  logic                      dc_busidle,
    output logic                      ic_busgrant,
    output logic                      dc_busgrant,

    input  logic                      ic_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] ic_req,
    input  logic [BUS_TAG_WIDTH-1:0]  ic_reqtag,
    input  logic                      ic_respack,
    output logic                      ic_reqack,
    output logic                      ic_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] ic_resp,
    output logic [BUS_TAG_WIDTH-1:0]  ic_resptag,

    input  logic                      dc_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] dc_req,
    input  logic [BUS_TAG_WIDTH-1:0]  dc_reqtag,
    input  logic                      dc_respack,
    output logic                      dc_reqack,
    output logic                      dc_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] dc_resp,
    output logic [BUS_TAG_WIDTH-1:0]  dc_resptag,

    output logic                      bus_reqcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respack,
    input  logic                      bus_reqack,
    input  logic                      bus_respcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    typedef enum logic [1:0] {IDLE, GNT_IC, GNT_DC, REL} state_t;

    localparam logic       OWNER_IC     = 1'b0;
    localparam logic       OWNER_DC     = 1'b1;
    localparam logic [4:0] TIMEOUT_LAST = 5'(START_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic       last_owner_q, last_owner_d;
    logic       started_q, started_d;
    logic [4:0] timer_q, timer_d;

    logic       own_ic, own_dc, own_idle, inv_bcast;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            last_owner_q <= OWNER_DC;   // IC wins the first tie
            started_q    <= 1'b0;
            timer_q      <= '0;
        end else begin
            state_q      <= state_d;
            last_owner_q <= last_owner_d;
            started_q    <= started_d;
            timer_q      <= timer_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        last_owner_d = last_owner_q;
        started_d    = started_q;
        timer_d      = timer_q;
        own_idle     = (state_q == GNT_DC) ? dc_busidle : ic_busidle;

        case (state_q)
            IDLE: begin
                // Clearing here means every new grant starts with a fresh timer.
                started_d = 1'b0;
                timer_d   = '0;
                if (ic_busreq && dc_busreq)
                    state_d = (last_owner_q == OWNER_IC) ? GNT_DC : GNT_IC;
                else if (ic_busreq)
                    state_d = GNT_IC;
                else if (dc_busreq)
                    state_d = GNT_DC;
            end
            GNT_IC, GNT_DC: begin
                if (started_q) begin
                    if (own_idle) begin
                        state_d      = REL;
                        last_owner_d = (state_q == GNT_DC) ? OWNER_DC : OWNER_IC;
                    end
                end else if (!own_idle) begin
                    started_d = 1'b1;
                end else if (timer_q >= TIMEOUT_LAST) begin
                    // Owner never started a transaction: take the bus back.
                    state_d      = REL;
                    last_owner_d = (state_q == GNT_DC) ? OWNER_DC : OWNER_IC;
                end else begin
                    timer_d = (timer_q == 5'h1f) ? timer_q : timer_q + 5'd1;
                end
            end
            REL: begin
                state_d   = IDLE;
                started_d = 1'b0;
                timer_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic: request mux and response routing
    always_comb begin
        own_ic      = (state_q == GNT_IC);
        own_dc      = (state_q == GNT_DC);
        ic_busgrant = own_ic;
        dc_busgrant = own_dc;

        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        if (own_ic) begin
            bus_reqcyc  = ic_reqcyc;
            bus_req     = ic_req;
            bus_reqtag  = ic_reqtag;
            bus_respack = ic_respack;
        end else if (own_dc) begin
            bus_reqcyc  = dc_reqcyc;
            bus_req     = dc_req;
            bus_reqtag  = dc_reqtag;
            bus_respack = dc_respack;
        end

        // Invalidates reach both caches whatever the ownership state.
        inv_bcast  = bus_respcyc && (bus_resptag == INV_TAG);
        ic_respcyc = inv_bcast || (own_ic && bus_respcyc);
        dc_respcyc = inv_bcast || (own_dc && bus_respcyc);
        ic_reqack  = own_ic && bus_reqack;
        dc_reqack  = own_dc && bus_reqack;

        ic_resp    = bus_resp;
        dc_resp    = bus_resp;
        ic_resptag = bus_resptag;
        dc_resptag = bus_resptag;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
//   Table-driven bench for mem_bus_arbiter: each vector is one clock cycle of
//   inputs plus the outputs expected during that cycle. Expectations are queued
//   when the stimulus is driven and popped by a monitor on the falling edge.
module tb_mem_bus_arbiter;

    localparam int DW = 64;
    localparam int TW = 13;

    typedef struct packed {
        logic          ic_busreq;
        logic          dc_busreq;
        logic          ic_busidle;
        logic          dc_busidle;
        logic          ic_reqcyc;
        logic          dc_reqcyc;
        logic [DW-1:0] ic_req;
        logic [DW-1:0] dc_req;
        logic [TW-1:0] ic_reqtag;
        logic [TW-1:0] dc_reqtag;
        logic          ic_respack;
        logic          dc_respack;
        logic          bus_reqack;
        logic          bus_respcyc;
        logic [DW-1:0] bus_resp;
        logic [TW-1:0] bus_resptag;
    } in_t;

    typedef struct packed {
        logic          ic_gnt;
        logic          dc_gnt;
        logic          bus_reqcyc;
        logic [DW-1:0] bus_req;
        logic [TW-1:0] bus_reqtag;
        logic          bus_respack;
        logic          ic_reqack;
        logic          dc_reqack;
        logic          ic_respcyc;
        logic          dc_respcyc;
        logic [DW-1:0] ic_resp;
        logic [TW-1:0] dc_resptag;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          ic_busreq, dc_busreq, ic_busidle, dc_busidle;
    logic          ic_busgrant, dc_busgrant;
    logic          ic_reqcyc, dc_reqcyc, ic_respack, dc_respack;
    logic [DW-1:0] ic_req, dc_req, ic_resp, dc_resp, bus_req, bus_resp;
    logic [TW-1:0] ic_reqtag, dc_reqtag, ic_resptag, dc_resptag, bus_reqtag, bus_resptag;
    logic          ic_reqack, dc_reqack, ic_respcyc, dc_respcyc;
    logic          bus_reqcyc, bus_respack, bus_reqack, bus_respcyc;

    always #5 clk = ~clk;

    mem_bus_arbiter dut (
        .clk         (clk),
        .reset       (reset),
        .ic_busreq   (ic_busreq),
        .dc_busreq   (dc_busreq),
        .ic_busidle  (ic_busidle),
        .dc_busidle  (dc_busidle),
        .ic_busgrant (ic_busgrant),
        .dc_busgrant (dc_busgrant),
        .ic_reqcyc   (ic_reqcyc),
        .ic_req      (ic_req),
        .ic_reqtag   (ic_reqtag),
        .ic_respack  (ic_respack),
        .ic_reqack   (ic_reqack),
        .ic_respcyc  (ic_respcyc),
        .ic_resp     (ic_resp),
        .ic_resptag  (ic_resptag),
        .dc_reqcyc   (dc_reqcyc),
        .dc_req      (dc_req),
        .dc_reqtag   (dc_reqtag),
        .dc_respack  (dc_respack),
        .dc_reqack   (dc_reqack),
        .dc_respcyc  (dc_respcyc),
        .dc_resp     (dc_resp),
        .dc_resptag  (dc_resptag),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_respack (bus_respack),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag)
    );

    out_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    out_t  mon_e, mon_a;
    string mon_nm;

    function automatic in_t base_in();
        in_t b;
        b = '0;
        b.ic_busidle = 1'b1;
        b.dc_busidle = 1'b1;
        return b;
    endfunction

    function automatic out_t mo(input logic ig, input logic dg, input logic rc,
                                input logic [DW-1:0] rq, input logic [TW-1:0] rt,
                                input logic ra, input logic iqa, input logic dqa,
                                input logic irc, input logic drc);
        out_t o;
        o = '0;
        o.ic_gnt      = ig;
        o.dc_gnt      = dg;
        o.bus_reqcyc  = rc;
        o.bus_req     = rq;
        o.bus_reqtag  = rt;
        o.bus_respack = ra;
        o.ic_reqack   = iqa;
        o.dc_reqack   = dqa;
        o.ic_respcyc  = irc;
        o.dc_respcyc  = drc;
        return o;
    endfunction

    function automatic out_t zero_out();
        return mo(0, 0, 0, '0, '0, 0, 0, 0, 0, 0);
    endfunction

    task automatic apply(input in_t i);
        ic_busreq   = i.ic_busreq;
        dc_busreq   = i.dc_busreq;
        ic_busidle  = i.ic_busidle;
        dc_busidle  = i.dc_busidle;
        ic_reqcyc   = i.ic_reqcyc;
        dc_reqcyc   = i.dc_reqcyc;
        ic_req      = i.ic_req;
        dc_req      = i.dc_req;
        ic_reqtag   = i.ic_reqtag;
        dc_reqtag   = i.dc_reqtag;
        ic_respack  = i.ic_respack;
        dc_respack  = i.dc_respack;
        bus_reqack  = i.bus_reqack;
        bus_respcyc = i.bus_respcyc;
        bus_resp    = i.bus_resp;
        bus_resptag = i.bus_resptag;
    endtask

    // Response data and tag are pure fanout of the bus inputs just driven.
    task automatic push_exp(input in_t i, input out_t e, input string nm);
        out_t x;
        x            = e;
        x.ic_resp    = i.bus_resp;
        x.dc_resptag = i.bus_resptag;
        exp_q.push_back(x);
        name_q.push_back(nm);
    endtask

    task automatic step(input in_t i, input out_t e, input string nm);
        @(posedge clk);
        #1;
        apply(i);
        push_exp(i, e, nm);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e  = exp_q.pop_front();
            mon_nm = name_q.pop_front();
            mon_a  = '{ic_gnt: ic_busgrant, dc_gnt: dc_busgrant, bus_reqcyc: bus_reqcyc,
                       bus_req: bus_req, bus_reqtag: bus_reqtag, bus_respack: bus_respack,
                       ic_reqack: ic_reqack, dc_reqack: dc_reqack, ic_respcyc: ic_respcyc,
                       dc_respcyc: dc_respcyc, ic_resp: ic_resp, dc_resptag: dc_resptag};
            n_cmp++;
            if (mon_a !== mon_e) begin
                n_bad++;
                $display("FAIL %s: got %h required %h", mon_nm, mon_a, mon_e);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    vec_t vt[9];
    in_t  s;

    initial begin
        // ---- table: DC alone, routing isolation, invalidate, release ----
        for (int k = 0; k < 9; k++) vt[k].in = base_in();
        vt[0].in.dc_busreq = 1;
        vt[0].exp = zero_out();

        vt[1].in.dc_busreq = 1;  vt[1].in.dc_busidle = 0;  vt[1].in.dc_reqcyc = 1;
        vt[1].in.dc_req = 64'h1000;  vt[1].in.dc_reqtag = 13'h1100;
        vt[1].in.ic_reqcyc = 1;  vt[1].in.ic_req = 64'h2222;  vt[1].in.ic_reqtag = 13'h0222;
        vt[1].exp = mo(0, 1, 1, 64'h1000, 13'h1100, 0, 0, 0, 0, 0);

        vt[2].in.dc_busidle = 0;  vt[2].in.dc_req = 64'h1000;  vt[2].in.dc_reqtag = 13'h1100;
        vt[2].in.ic_reqcyc = 1;  vt[2].in.bus_reqack = 1;
        vt[2].exp = mo(0, 1, 0, 64'h1000, 13'h1100, 0, 0, 1, 0, 0);

        vt[3].in.dc_busidle = 0;  vt[3].in.dc_req = 64'h1000;  vt[3].in.dc_reqtag = 13'h1100;
        vt[3].in.bus_respcyc = 1;  vt[3].in.bus_resptag = 13'h100;  vt[3].in.bus_resp = 64'h1234;
        vt[3].in.dc_respack = 1;  vt[3].in.ic_respack = 1;
        vt[3].exp = mo(0, 1, 0, 64'h1000, 13'h1100, 1, 0, 0, 0, 1);

        vt[4].in.dc_busidle = 0;  vt[4].in.dc_req = 64'h1000;  vt[4].in.dc_reqtag = 13'h1100;
        vt[4].in.bus_respcyc = 1;  vt[4].in.bus_resptag = 13'h800;
        vt[4].in.bus_resp = 64'h0000_dead_beef_0000;
        vt[4].exp = mo(0, 1, 0, 64'h1000, 13'h1100, 0, 0, 0, 1, 1);

        vt[5].in.dc_req = 64'h1000;  vt[5].in.dc_reqtag = 13'h1100;
        vt[5].exp = mo(0, 1, 0, 64'h1000, 13'h1100, 0, 0, 0, 0, 0);

        vt[6].in.dc_reqcyc = 1;  vt[6].in.dc_req = 64'h5555;
        vt[6].in.bus_respcyc = 1;  vt[6].in.bus_resptag = 13'h800;  vt[6].in.bus_resp = 64'habcd;
        vt[6].exp = mo(0, 0, 0, '0, '0, 0, 0, 0, 1, 1);

        vt[7].in.bus_respcyc = 1;  vt[7].in.bus_resptag = 13'h100;  vt[7].in.bus_reqack = 1;
        vt[7].exp = zero_out();

        vt[8].in.bus_resptag = 13'h800;
        vt[8].exp = zero_out();

        // ---- reset state: requests present while reset is held ----
        s = base_in();
        s.ic_busreq = 1;  s.dc_busreq = 1;  s.bus_reqack = 1;  s.dc_reqcyc = 1;
        s.dc_req = 64'h99;  s.bus_respcyc = 1;  s.bus_resptag = 13'h100;
        apply(base_in());
        step(s, zero_out(), "reset_state");
        @(negedge clk);
        #1;
        apply(base_in());
        reset = 1'b1;

        for (int k = 0; k < 9; k++) step(vt[k].in, vt[k].exp, $sformatf("table_row%0d", k));

        // ---- tie after a DC release: IC wins, DC granted after REL+IDLE ----
        s = base_in();  s.ic_busreq = 1;  s.dc_busreq = 1;
        step(s, zero_out(), "tie_idle");
        s = base_in();  s.dc_busreq = 1;  s.ic_busidle = 0;  s.ic_reqcyc = 1;
        s.ic_req = 64'ha0;  s.ic_reqtag = 13'h0a;
        step(s, mo(1, 0, 1, 64'ha0, 13'h0a, 0, 0, 0, 0, 0), "tie_ic_wins");
        s = base_in();  s.dc_busreq = 1;
        step(s, mo(1, 0, 0, '0, '0, 0, 0, 0, 0, 0), "ic_release_cycle");
        step(s, zero_out(), "release_rel_gap");
        step(s, zero_out(), "release_idle_gap");
        s.dc_busidle = 0;
        step(s, mo(0, 1, 0, '0, '0, 0, 0, 0, 0, 0), "dc_after_gap");
        step(base_in(), mo(0, 1, 0, '0, '0, 0, 0, 0, 0, 0), "dc_release_cycle");
        step(base_in(), zero_out(), "dc_rel");
        step(base_in(), zero_out(), "dc_idle");

        // ---- timeout: IC granted but never starts ----
        s = base_in();  s.ic_busreq = 1;  s.dc_busreq = 1;
        step(s, zero_out(), "to_request");
        s = base_in();  s.dc_busreq = 1;
        for (int k = 1; k <= 16; k++)
            step(s, mo(1, 0, 0, '0, '0, 0, 0, 0, 0, 0), $sformatf("to_hold%0d", k));
        step(s, zero_out(), "to_rel");
        step(s, zero_out(), "to_idle");
        s.dc_busidle = 0;
        step(s, mo(0, 1, 0, '0, '0, 0, 0, 0, 0, 0), "to_dc_gnt");
        step(base_in(), mo(0, 1, 0, '0, '0, 0, 0, 0, 0, 0), "to_dc_release");
        step(base_in(), zero_out(), "to_dc_rel");
        step(base_in(), zero_out(), "to_dc_idle");

        // ---- IC transaction so last_owner becomes IC ----
        s = base_in();  s.ic_busreq = 1;
        step(s, zero_out(), "ic_only_req");
        s = base_in();  s.ic_busidle = 0;
        step(s, mo(1, 0, 0, '0, '0, 0, 0, 0, 0, 0), "ic_only_gnt");
        step(base_in(), mo(1, 0, 0, '0, '0, 0, 0, 0, 0, 0), "ic_only_release");
        step(base_in(), zero_out(), "ic_only_rel");
        step(base_in(), zero_out(), "ic_only_idle");

        // ---- async reset mid-burst while DC owns ----
        s = base_in();  s.dc_busreq = 1;
        step(s, zero_out(), "burst_req");
        s = base_in();  s.dc_busidle = 0;  s.dc_reqcyc = 1;
        s.dc_req = 64'h77;  s.dc_reqtag = 13'h7;
        step(s, mo(0, 1, 1, 64'h77, 13'h7, 0, 0, 0, 0, 0), "burst_owned");
        @(posedge clk);
        #1;
        apply(s);
        #1;
        reset = 1'b0;
        push_exp(s, zero_out(), "reset_mid_burst");
        #1;
        if (dc_busgrant !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async_dc_gnt: got %b required 0", dc_busgrant);
        end
        if (ic_busgrant !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async_ic_gnt: got %b required 0", ic_busgrant);
        end
        if (bus_reqcyc !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_async_reqcyc: got %b required 0", bus_reqcyc);
        end
        step(base_in(), zero_out(), "reset_held");
        #2;
        reset = 1'b1;
        s = base_in();  s.ic_busreq = 1;  s.dc_busreq = 1;
        step(s, zero_out(), "post_reset_tie_idle");
        s = base_in();  s.ic_busidle = 0;
        step(s, mo(1, 0, 0, '0, '0, 0, 0, 0, 0, 0), "post_reset_ic_wins");
        step(base_in(), mo(1, 0, 0, '0, '0, 0, 0, 0, 0, 0), "post_reset_release");
        step(base_in(), zero_out(), "post_reset_rel");

        @(negedge clk);
        #1;
        if (n_cmp < 12) begin
            n_bad++;
            $display("FAIL too_few_compares: %0d", n_cmp);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
